// File: rtl/sc_backg_pkg.sv
// Shared types and constants for the background-lane sequencer.
package sc_backg_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        RUN    = 3'd2,
        PAUSED = 3'd3,
        LOAD   = 3'd4
    } backgState_t;

    localparam logic [1:0] SHIFT_NONE  = 2'b00;
    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;

    localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/sc_period_counter.sv
// Up-counter with synchronous clear and enable; wraps at period-1 and flags the wrap combinationally.
module sc_period_counter #(
    parameter int WIDTH = 24
) (
    input  logic             SC_PERIODCOUNTER_CLOCK_50,
    input  logic             SC_PERIODCOUNTER_RESET_InHigh,
    input  logic             SC_PERIODCOUNTER_clear_InHigh,
    input  logic             SC_PERIODCOUNTER_enable_InHigh,
    input  logic [WIDTH-1:0] SC_PERIODCOUNTER_period_In,
    output logic             SC_PERIODCOUNTER_wrap_Out
);

    logic [WIDTH-1:0] countReg;

    // >= rather than == keeps the counter safe should the period ever shrink below the count
    assign SC_PERIODCOUNTER_wrap_Out = SC_PERIODCOUNTER_enable_InHigh &&
        (countReg >= (SC_PERIODCOUNTER_period_In - WIDTH'(1)));

    always_ff @(posedge SC_PERIODCOUNTER_CLOCK_50 or posedge SC_PERIODCOUNTER_RESET_InHigh) begin
        if (SC_PERIODCOUNTER_RESET_InHigh) begin
            countReg <= '0;
        end else if (SC_PERIODCOUNTER_clear_InHigh) begin
            countReg <= '0;
        end else if (SC_PERIODCOUNTER_enable_InHigh) begin
            countReg <= SC_PERIODCOUNTER_wrap_Out ? '0 : countReg + WIDTH'(1);
        end
    end

endmodule

// File: rtl/sc_statemachine_backg.sv
// Lane sequencer: drives clear/load/shift-select of one background-lane shift register.
module sc_statemachine_backg
    import sc_backg_pkg::*;
#(
    parameter int PRESCALER_WIDTH = 24,
    parameter int BASE_PERIOD     = 5000000,
    parameter int DIRECTION       = 0
) (
    input  logic       SC_STATEMACHINEBACKG_CLOCK_50,
    input  logic       SC_STATEMACHINEBACKG_RESET_InHigh,
    input  logic       SC_STATEMACHINEBACKG_start_InLow,
    input  logic       SC_STATEMACHINEBACKG_collision_InLow,
    input  logic       SC_STATEMACHINEBACKG_levelup_InHigh,
    input  logic       SC_STATEMACHINEBACKG_pause_InHigh,
    input  logic [1:0] SC_STATEMACHINEBACKG_speed_In,
    output logic       SC_STATEMACHINEBACKG_clear_OutLow,
    output logic       SC_STATEMACHINEBACKG_load_OutLow,
    output logic [1:0] SC_STATEMACHINEBACKG_shiftselection_Out,
    output logic       SC_STATEMACHINEBACKG_running_Out
);

    localparam logic [PRESCALER_WIDTH-1:0] BASE_P = PRESCALER_WIDTH'(BASE_PERIOD);
    localparam logic [PRESCALER_WIDTH-1:0] MIN_P  = PRESCALER_WIDTH'(MIN_PERIOD);
    localparam logic [1:0] SHIFT_CODE = (DIRECTION != 0) ? SHIFT_RIGHT : SHIFT_LEFT;

    backgState_t                stateReg, stateNext;
    logic [PRESCALER_WIDTH-1:0] periodReg;
    logic [PRESCALER_WIDTH-1:0] shiftedPeriod, periodSel;
    logic                       strobeReg;
    logic                       counterClr, counterEn, periodLoad, wrap;

    always_comb begin
        shiftedPeriod = BASE_P >> SC_STATEMACHINEBACKG_speed_In;
        periodSel     = (shiftedPeriod < MIN_P) ? MIN_P : shiftedPeriod;
    end

    // The PAUSED->RUN cycle also counts, so a k-cycle pause delays the strobe by exactly k
    always_comb begin
        stateNext  = stateReg;
        counterClr = 1'b0;
        counterEn  = 1'b0;
        periodLoad = 1'b0;
        unique case (stateReg)
            IDLE: begin
                if (!SC_STATEMACHINEBACKG_start_InLow) stateNext = CLEAR;
            end
            CLEAR: begin
                stateNext  = RUN;
                counterClr = 1'b1;
                periodLoad = 1'b1;
            end
            RUN: begin
                if (!SC_STATEMACHINEBACKG_collision_InLow)    stateNext = CLEAR;
                else if (SC_STATEMACHINEBACKG_levelup_InHigh) stateNext = LOAD;
                else if (SC_STATEMACHINEBACKG_pause_InHigh)   stateNext = PAUSED;
                else                                          counterEn = 1'b1;
            end
            PAUSED: begin
                if (!SC_STATEMACHINEBACKG_collision_InLow) begin
                    stateNext = CLEAR;
                end else if (!SC_STATEMACHINEBACKG_pause_InHigh) begin
                    stateNext = RUN;
                    counterEn = 1'b1;
                end
            end
            LOAD: begin
                if (!SC_STATEMACHINEBACKG_collision_InLow) begin
                    stateNext = CLEAR;
                end else begin
                    stateNext  = RUN;
                    counterClr = 1'b1;
                    periodLoad = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    sc_period_counter #(
        .WIDTH(PRESCALER_WIDTH)
    ) periodCounter (
        .SC_PERIODCOUNTER_CLOCK_50      (SC_STATEMACHINEBACKG_CLOCK_50),
        .SC_PERIODCOUNTER_RESET_InHigh  (SC_STATEMACHINEBACKG_RESET_InHigh),
        .SC_PERIODCOUNTER_clear_InHigh  (counterClr),
        .SC_PERIODCOUNTER_enable_InHigh (counterEn),
        .SC_PERIODCOUNTER_period_In     (periodReg),
        .SC_PERIODCOUNTER_wrap_Out      (wrap)
    );

    always_ff @(posedge SC_STATEMACHINEBACKG_CLOCK_50 or posedge SC_STATEMACHINEBACKG_RESET_InHigh) begin
        if (SC_STATEMACHINEBACKG_RESET_InHigh) begin
            stateReg  <= IDLE;
            periodReg <= MIN_P;
            strobeReg <= 1'b0;
        end else begin
            stateReg  <= stateNext;
            strobeReg <= wrap;
            if (periodLoad || wrap) periodReg <= periodSel;
        end
    end

    assign SC_STATEMACHINEBACKG_clear_OutLow       = (stateReg != CLEAR);
    assign SC_STATEMACHINEBACKG_load_OutLow        = (stateReg != LOAD);
    assign SC_STATEMACHINEBACKG_shiftselection_Out = strobeReg ? SHIFT_CODE : SHIFT_NONE;
    assign SC_STATEMACHINEBACKG_running_Out        = (stateReg == RUN) || (stateReg == PAUSED);

endmodule

// File: tb/tb_sc_statemachine_backg.sv
// Directed and randomized bench for sc_statemachine_backg against a countdown-based lane model.
module tb_sc_statemachine_backg;

    localparam int BASE = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       startN = 1'b1;
    logic       collN = 1'b1;
    logic       levelup = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] speed = 2'd0;
    logic       clearN, loadN, running;
    logic [1:0] shiftSel;

    int assertCount = 0;
    int failCount = 0;

    typedef enum int {M_IDLE, M_CLEAR, M_RUN, M_PAUSED, M_LOAD} modelPhase_t;
    modelPhase_t phase = M_IDLE;
    int  cyclesLeft = 0;
    bit  strobeExp = 1'b0;

    sc_statemachine_backg #(
        .PRESCALER_WIDTH(24),
        .BASE_PERIOD    (BASE),
        .DIRECTION      (0)
    ) dut (
        .SC_STATEMACHINEBACKG_CLOCK_50          (clk),
        .SC_STATEMACHINEBACKG_RESET_InHigh      (rst),
        .SC_STATEMACHINEBACKG_start_InLow       (startN),
        .SC_STATEMACHINEBACKG_collision_InLow   (collN),
        .SC_STATEMACHINEBACKG_levelup_InHigh    (levelup),
        .SC_STATEMACHINEBACKG_pause_InHigh      (pause),
        .SC_STATEMACHINEBACKG_speed_In          (speed),
        .SC_STATEMACHINEBACKG_clear_OutLow      (clearN),
        .SC_STATEMACHINEBACKG_load_OutLow       (loadN),
        .SC_STATEMACHINEBACKG_shiftselection_Out(shiftSel),
        .SC_STATEMACHINEBACKG_running_Out       (running)
    );

    always #5 clk = ~clk;

    function automatic int expPeriod(input logic [1:0] s);
        int p;
        p = BASE >> s;
        return (p < 2) ? 2 : p;
    endfunction

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkOutputs(input string tag);
        chk({tag, ".clear"},   {1'b0, clearN},   {1'b0, phase != M_CLEAR});
        chk({tag, ".load"},    {1'b0, loadN},    {1'b0, phase != M_LOAD});
        chk({tag, ".shift"},   shiftSel,         strobeExp ? 2'b01 : 2'b00);
        chk({tag, ".running"}, {1'b0, running},  {1'b0, (phase == M_RUN) || (phase == M_PAUSED)});
    endtask

    // One active cycle of lane time; a strobe fires when the countdown for the current period expires.
    task automatic modelTick(output bit fire);
        fire = 1'b0;
        cyclesLeft--;
        if (cyclesLeft == 0) begin
            fire = 1'b1;
            cyclesLeft = expPeriod(speed);
        end
    endtask

    task automatic modelEdge();
        bit fire;
        fire = 1'b0;
        if (rst) begin
            phase = M_IDLE;
        end else begin
            case (phase)
                M_IDLE:  if (!startN) phase = M_CLEAR;
                M_CLEAR: begin phase = M_RUN; cyclesLeft = expPeriod(speed); end
                M_RUN: begin
                    if (!collN)       phase = M_CLEAR;
                    else if (levelup) phase = M_LOAD;
                    else if (pause)   phase = M_PAUSED;
                    else              modelTick(fire);
                end
                M_PAUSED: begin
                    if (!collN) phase = M_CLEAR;
                    else if (!pause) begin phase = M_RUN; modelTick(fire); end
                end
                M_LOAD: begin
                    if (!collN) phase = M_CLEAR;
                    else begin phase = M_RUN; cyclesLeft = expPeriod(speed); end
                end
                default: phase = M_IDLE;
            endcase
        end
        strobeExp = fire;
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        modelEdge();
        #1;
        checkOutputs(tag);
    endtask

    task automatic runCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(tag);
    endtask

    initial begin
        int strobeSeen;
        int guard;

        // 1. reset and idle
        #1;
        checkOutputs("reset");
        runCycles(2, "reset_hold");
        rst = 1'b0;
        strobeSeen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc("idle");
            if (shiftSel != 2'b00) strobeSeen++;
        end
        chk("idle_no_strobe", strobeSeen[1:0], 2'b00);

        // 2. start at speed 0
        startN = 1'b0;
        cyc("start");
        startN = 1'b1;
        runCycles(26, "run_speed0");

        // 3. speed change mid-period, then clamped speed 3
        runCycles(3, "pre_speed");
        speed = 2'd2;
        runCycles(20, "speed2");
        speed = 2'd3;
        runCycles(12, "speed3");
        speed = 2'd0;
        runCycles(10, "speed0_again");

        // 4. pause with the counter at 3
        guard = 0;
        while (!strobeExp && guard < 40) begin cyc("seek_strobe"); guard++; end
        chk("seek_strobe_bound", {1'b0, guard < 40}, 2'b01);
        runCycles(3, "pre_pause");
        pause = 1'b1;
        runCycles(5, "paused");
        pause = 1'b0;
        runCycles(14, "resume");

        // 5. levelup in RUN, then levelup ignored while PAUSED
        levelup = 1'b1;
        cyc("levelup");
        levelup = 1'b0;
        runCycles(12, "post_load");
        pause = 1'b1;
        runCycles(2, "pause_lvl");
        levelup = 1'b1;
        cyc("levelup_paused");
        levelup = 1'b0;
        runCycles(2, "pause_lvl2");
        pause = 1'b0;
        runCycles(10, "post_pause_lvl");

        // 6. collision in the wrap cycle, collision during CLEAR, async reset in PAUSED
        guard = 0;
        while (!(phase == M_RUN && cyclesLeft == 1) && guard < 40) begin cyc("seek_wrap"); guard++; end
        chk("seek_wrap_bound", {1'b0, guard < 40}, 2'b01);
        collN = 1'b0;
        cyc("coll_wrap");
        chk("coll_wrap_clear", {1'b0, clearN}, 2'b00);
        chk("coll_wrap_noshift", shiftSel, 2'b00);
        cyc("coll_in_clear");
        collN = 1'b1;
        runCycles(10, "post_coll");
        pause = 1'b1;
        runCycles(3, "pre_reset_pause");
        rst = 1'b1;
        #1;
        phase = M_IDLE;
        strobeExp = 1'b0;
        chk("async_clear",   {1'b0, clearN},  2'b01);
        chk("async_load",    {1'b0, loadN},   2'b01);
        chk("async_shift",   shiftSel,        2'b00);
        chk("async_running", {1'b0, running}, 2'b00);
        pause = 1'b0;
        cyc("reset_held");
        rst = 1'b0;
        runCycles(5, "post_reset_idle");

        // 7. randomized traffic
        for (int i = 0; i < 800; i++) begin
            startN  = ($urandom_range(0, 7) != 0);
            collN   = ($urandom_range(0, 39) != 0);
            levelup = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 14) == 0) pause = ~pause;
            if ($urandom_range(0, 19) == 0) speed = 2'($urandom_range(0, 3));
            cyc("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
